// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared types and constants for the RGMII receive frame path
package rgmii_pkg;

    // Frame delineation states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Ethernet CRC-32 in normal (MSB-first) notation; the datapath uses its reflection
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    // Good-frame residue in normal bit order (reflected register reads 0xDEBB20E3)
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // In-band status speed encoding carried on RXD[2:1] during the IFG
    localparam logic [1:0]  SPEED_10      = 2'b00;
    localparam logic [1:0]  SPEED_100     = 2'b01;
    localparam logic [1:0]  SPEED_1000    = 2'b10;

    // Reverse bit order of a 32-bit word (LSB-first register <-> MSB-first notation)
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rgmii_rx_crc32.sv
// rtl/rgmii_rx_crc32.sv - byte-wide reflected CRC-32 accumulator with clear and enable
module rgmii_rx_crc32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    import rgmii_pkg::*;

    localparam logic [31:0] POLY_REFL = bitrev32(CRC_POLY);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] c;

    // Next CRC: clear wins, otherwise fold one byte LSB first
    always_comb begin
        crc_d = crc_q;
        c     = crc_q ^ {24'h0, data_i};
        if (clr_i) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (en_i) begin
            for (int i = 0; i < 8; i++) begin
                c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
            end
            crc_d = c;
        end
    end

    // CRC register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= 32'hFFFF_FFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/rgmii_rx_frame.sv
// rtl/rgmii_rx_frame.sv - RGMII DDR capture, frame delineation and status; CRC check under RGMII_RX_FRAME_CRC_EN
module rgmii_rx_frame #(
    parameter int IODLY   = 63,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rgmii_rxd,
    input  logic        rgmii_rx_ctl,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        duplex,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
);
    import rgmii_pkg::*;

    localparam int              LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
    // The delay line is ideal in this portable model; an illegal tap setting blanks the inputs
    localparam bit              IODLY_OK = (IODLY >= 0) && (IODLY <= 127);

    logic [1:0]       rst_sync_q;
    logic             rst_ni;
    logic [4:0]       pin_w;
    logic [4:0]       rise_q, fall_q, q0_q, q1_q;
    logic [7:0]       byte_q;
    logic             dv_q, er_q;
    rx_state_e        state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             hold_sof_q, hold_sof_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_seen_q, err_seen_d;
    logic             link_q, link_d, duplex_q, duplex_d;
    logic [1:0]       speed_q, speed_d;
    logic             emit, emit_sof, emit_eof, emit_err;
    logic             crc_bad;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q, rx_sof_q, rx_eof_q, rx_err_q;
    logic [15:0]      ok_cnt_q, err_cnt_q;

    // Reset: assert asynchronously, release on clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_ni = rst_sync_q[1];

    assign pin_w = IODLY_OK ? {rgmii_rx_ctl, rgmii_rxd} : 5'h00;

    // IDDR rising-edge capture
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= 5'h00;
        end else begin
            rise_q <= pin_w;
        end
    end

    // IDDR falling-edge capture
    always_ff @(negedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            fall_q <= 5'h00;
        end else begin
            fall_q <= pin_w;
        end
    end

    // IDDR output: both halves of one RXC period presented on the same rising edge
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            q0_q <= 5'h00;
            q1_q <= 5'h00;
        end else begin
            q0_q <= rise_q;
            q1_q <= fall_q;
        end
    end

    // Byte assembly: high nibble on the falling edge, RX_CTL carries DV then DV^ER
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_q <= 8'h00;
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
        end else begin
            byte_q <= {q1_q[3:0], q0_q[3:0]};
            dv_q   <= q0_q[4];
            er_q   <= q0_q[4] ^ q1_q[4];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dv_q) begin
                    state_d = (byte_q == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end else if (er_q) begin
                    state_d = ST_DROP;
                end else if (byte_q == SFD_BYTE) begin
                    state_d = ST_DATA;
                end else if (byte_q != PREAMBLE_BYTE) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end else if (len_q == LEN_LAST) begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // FSM outputs: one-byte hold so the last byte can be tagged when DV falls
    always_comb begin
        emit       = 1'b0;
        emit_sof   = hold_sof_q;
        emit_eof   = 1'b0;
        emit_err   = 1'b0;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        hold_sof_d = hold_sof_q;
        len_d      = len_q;
        err_seen_d = err_seen_q;
        link_d     = link_q;
        speed_d    = speed_q;
        duplex_d   = duplex_q;
        case (state_q)
            ST_IDLE: begin
                hold_vld_d = 1'b0;
                len_d      = '0;
                err_seen_d = 1'b0;
                if (!dv_q && !er_q) begin
                    link_d   = byte_q[0];
                    speed_d  = byte_q[2:1];
                    duplex_d = byte_q[3];
                end
            end
            ST_PREAMBLE: begin
                hold_vld_d = 1'b0;
                len_d      = '0;
                err_seen_d = 1'b0;
            end
            ST_DATA: begin
                if (dv_q) begin
                    emit       = hold_vld_q;
                    hold_d     = byte_q;
                    hold_vld_d = 1'b1;
                    hold_sof_d = !hold_vld_q;
                    len_d      = len_q + LEN_W'(1);
                    err_seen_d = err_seen_q | er_q;
                end else begin
                    emit       = hold_vld_q;
                    emit_eof   = 1'b1;
                    emit_err   = err_seen_q | (len_q < LEN_MIN) | crc_bad;
                    hold_vld_d = 1'b0;
                end
            end
            default: begin
                // Only a truncated frame arrives here with a held byte
                emit       = hold_vld_q;
                emit_eof   = 1'b1;
                emit_err   = 1'b1;
                hold_vld_d = 1'b0;
            end
        endcase
    end

    // Frame datapath and in-band status registers
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            hold_sof_q <= 1'b0;
            len_q      <= '0;
            err_seen_q <= 1'b0;
            link_q     <= 1'b0;
            speed_q    <= 2'b00;
            duplex_q   <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            hold_sof_q <= hold_sof_d;
            len_q      <= len_d;
            err_seen_q <= err_seen_d;
            link_q     <= link_d;
            speed_q    <= speed_d;
            duplex_q   <= duplex_d;
        end
    end

    // Output byte stream and saturating frame counters
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_sof_q   <= 1'b0;
            rx_eof_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            ok_cnt_q   <= 16'h0000;
            err_cnt_q  <= 16'h0000;
        end else begin
            rx_valid_q <= emit;
            rx_sof_q   <= emit & emit_sof;
            rx_eof_q   <= emit & emit_eof;
            rx_err_q   <= emit & emit_eof & emit_err;
            if (emit) begin
                rx_data_q <= hold_q;
            end
            if (emit && emit_eof) begin
                if (emit_err) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                end else if (ok_cnt_q != 16'hFFFF) begin
                    ok_cnt_q <= ok_cnt_q + 16'd1;
                end
            end
        end
    end

`ifdef RGMII_RX_FRAME_CRC_EN
    logic [31:0] crc_w;
    logic        crc_clr;
    logic        crc_en;

    // CRC restarts outside DATA and folds in every byte accepted in DATA
    always_comb begin
        crc_clr = (state_q != ST_DATA);
        crc_en  = (state_q == ST_DATA) && dv_q;
    end

    rgmii_rx_crc32 u_crc (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .data_i (byte_q),
        .crc_o  (crc_w)
    );

    assign crc_bad = (bitrev32(crc_w) != CRC_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_sof   = rx_sof_q;
    assign rx_eof   = rx_eof_q;
    assign rx_err   = rx_err_q;
    assign link_up  = link_q;
    assign speed    = speed_q;
    assign duplex   = duplex_q;
    assign ok_cnt   = ok_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_rgmii_rx_frame.sv
// tb/tb_rgmii_rx_frame.sv - directed scoreboard bench for rgmii_rx_frame
module tb_rgmii_rx_frame;
    import rgmii_pkg::*;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rgmii_rxd = 4'h0;
    logic        rgmii_rx_ctl = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_err;
    logic        link_up;
    logic [1:0]  speed;
    logic        duplex;
    logic [15:0] ok_cnt, err_cnt;

    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         exp_ok = 0;
    int         exp_err = 0;
    logic [3:0] idle_nib = 4'h0;

    rgmii_rx_frame #(
        .IODLY   (63),
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rgmii_rxd    (rgmii_rxd),
        .rgmii_rx_ctl (rgmii_rx_ctl),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_err       (rx_err),
        .link_up      (link_up),
        .speed        (speed),
        .duplex       (duplex),
        .ok_cnt       (ok_cnt),
        .err_cnt      (err_cnt)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Output monitor: every valid byte must match the head of the scoreboard
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output observed=%0h expected=none", rx_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rx_data", {24'h0, rx_data}, {24'h0, e.data});
                chk("rx_sof", {31'h0, rx_sof}, {31'h0, e.sof});
                chk("rx_eof", {31'h0, rx_eof}, {31'h0, e.eof});
                chk("rx_err", {31'h0, rx_err}, {31'h0, e.err});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    // One RXC period: rising half (low nibble, DV), falling half (high nibble, DV^ER)
    task automatic send_byte(input logic [7:0] b, input logic dv, input logic er,
                             input bit push, input bit sof, input bit eof, input bit err);
        @(negedge clk);
        #2;
        rgmii_rxd    = b[3:0];
        rgmii_rx_ctl = dv;
        if (push) sb.push_back('{data: b, sof: sof, eof: eof, err: err, cyc: cyc + 5});
        @(posedge clk);
        #2;
        rgmii_rxd    = b[7:4];
        rgmii_rx_ctl = dv ^ er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_byte({idle_nib, idle_nib}, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) send_byte(PREAMBLE_BYTE, 1'b1, 1'b0, 0, 0, 0, 0);
        send_byte(SFD_BYTE, 1'b1, 1'b0, 0, 0, 0, 0);
    endtask

    // n bytes after SFD (last 4 are a valid FCS when n >= 4), optional ER on index er_idx
    task automatic send_frame(input int n, input int er_idx);
        logic [7:0]  fb[$];
        logic [31:0] crc;
        logic [31:0] fcs;
        int          out_n;
        bit          bad;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < ((n >= 4) ? n - 4 : n); i++) begin
            fb.push_back(8'(i + 16));
            crc = crc ^ {24'h0, 8'(i + 16)};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        fcs = ~crc;
        if (n >= 4) for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
        out_n = (n >= MAX_LEN) ? MAX_LEN : n;
        bad   = (n >= MAX_LEN) || (out_n < MIN_LEN) || (er_idx >= 0 && er_idx < out_n);
        preamble();
        for (int i = 0; i < n; i++)
            send_byte(fb[i], 1'b1, (i == er_idx), (i < out_n), (i == 0), (i == out_n - 1),
                      (i == out_n - 1) && bad);
        idle(12);
        if (out_n > 0) begin
            if (bad) exp_err++;
            else     exp_ok++;
        end
        chk("ok_cnt", {16'h0, ok_cnt}, exp_ok);
        chk("err_cnt", {16'h0, err_cnt}, exp_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_valid"}, {31'h0, rx_valid}, 0);
        chk({tag, "_rx_sof"}, {31'h0, rx_sof}, 0);
        chk({tag, "_rx_eof"}, {31'h0, rx_eof}, 0);
        chk({tag, "_rx_err"}, {31'h0, rx_err}, 0);
        chk({tag, "_rx_data"}, {24'h0, rx_data}, 0);
        chk({tag, "_link_up"}, {31'h0, link_up}, 0);
        chk({tag, "_speed"}, {30'h0, speed}, 0);
        chk({tag, "_duplex"}, {31'h0, duplex}, 0);
        chk({tag, "_ok_cnt"}, {16'h0, ok_cnt}, 0);
        chk({tag, "_err_cnt"}, {16'h0, err_cnt}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(6);

        // Good 64-byte frame
        send_frame(64, -1);
        // Same frame with ER on byte 10
        send_frame(64, 9);
        // Length boundaries: 1-byte, zero-byte, one short of minimum
        send_frame(1, -1);
        send_frame(0, -1);
        send_frame(63, -1);

        // Broken preamble: dropped until DV falls, next frame fine
        send_byte(8'h55, 1'b1, 1'b0, 0, 0, 0, 0);
        send_byte(8'h55, 1'b1, 1'b0, 0, 0, 0, 0);
        send_byte(8'h5A, 1'b1, 1'b0, 0, 0, 0, 0);
        send_byte(SFD_BYTE, 1'b1, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 16), 1'b1, 1'b0, 0, 0, 0, 0);
        idle(6);
        send_frame(64, -1);

        // Oversize frame truncated at MAX_LEN, then recovery
        send_frame(2000, -1);
        send_frame(64, -1);

        // In-band status from the IFG nibble
        idle_nib = 4'hD;
        idle(6);
        chk("link_up", {31'h0, link_up}, 1);
        chk("speed", {30'h0, speed}, {30'h0, SPEED_1000});
        chk("duplex", {31'h0, duplex}, 1);

        // Reset in the middle of a frame
        preamble();
        for (int i = 0; i < 30; i++) send_byte(8'(i + 16), 1'b1, 1'b0, 1, (i == 0), 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        while (sb.size() != 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        exp_ok  = 0;
        exp_err = 0;
        chk_all_zero("midreset");
        for (int i = 30; i < 64; i++) begin
            if (i == 33) rst_n = 1'b1;
            send_byte(8'(i + 16), 1'b1, 1'b0, 0, 0, 0, 0);
        end
        idle(12);
        send_frame(64, -1);

        idle(10);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
